// File: rtl/serial_crc_unit.sv
// serial_crc_unit: bit-serial, MSB-first CRC engine with a valid/ready input
// stream and a held result that the consumer releases with crc_ack.
module serial_crc_unit #(
    parameter int              WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = 8'h07,
    parameter logic [WIDTH-1:0] INIT  = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic             in_last,
    output logic [WIDTH-1:0] crc_out,
    output logic [15:0]      frame_len,
    output logic             crc_valid,
    input  logic             crc_ack
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    // One CRC shift step: feedback is the register MSB xor the incoming bit.
    function automatic logic [WIDTH-1:0] crc_step(input logic [WIDTH-1:0] crc_in,
                                                  input logic             data_bit);
        logic fb;
        fb = crc_in[WIDTH-1] ^ data_bit;
        if (fb) begin
            crc_step = {crc_in[WIDTH-2:0], 1'b0} ^ POLY;
        end else begin
            crc_step = {crc_in[WIDTH-2:0], 1'b0};
        end
    endfunction

    // Bit counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] cnt_in);
        if (cnt_in == 16'hFFFF) begin
            sat_inc = cnt_in;
        end else begin
            sat_inc = cnt_in + 16'd1;
        end
    endfunction

    state_t           state_r, state_next_s;
    logic [WIDTH-1:0] crc_r, crc_next_s;
    logic [15:0]      cnt_r, cnt_next_s;
    logic [WIDTH-1:0] crc_out_r, crc_out_next_s;
    logic [15:0]      frame_len_r, frame_len_next_s;
    logic             crc_valid_r, crc_valid_next_s;
    logic             in_ready_r;
    logic             beat_s;
    logic [WIDTH-1:0] crc_base_s;
    logic [WIDTH-1:0] crc_step_s;
    logic [15:0]      cnt_inc_s;

    // in_ready_r is low exactly in HOLD, so a beat can never land there.
    assign beat_s     = in_valid & in_ready_r;
    // A frame always starts from INIT, independent of leftover register contents.
    assign crc_base_s = (state_r == S_IDLE) ? INIT : crc_r;
    assign crc_step_s = crc_step(crc_base_s, in_bit);
    assign cnt_inc_s  = sat_inc(cnt_r);

    assign in_ready  = in_ready_r;
    assign crc_out   = crc_out_r;
    assign frame_len = frame_len_r;
    assign crc_valid = crc_valid_r;

    // Next-state and next-result logic for the IDLE/SHIFT/HOLD sequencer.
    always_comb begin
        state_next_s     = state_r;
        crc_next_s       = crc_r;
        cnt_next_s       = cnt_r;
        crc_out_next_s   = crc_out_r;
        frame_len_next_s = frame_len_r;
        crc_valid_next_s = crc_valid_r;
        case (state_r)
            S_IDLE, S_SHIFT: begin
                if (beat_s) begin
                    crc_next_s = crc_step_s;
                    cnt_next_s = cnt_inc_s;
                    if (in_last) begin
                        state_next_s     = S_HOLD;
                        crc_valid_next_s = 1'b1;
                        crc_out_next_s   = crc_step_s;
                        frame_len_next_s = cnt_inc_s;
                    end else begin
                        state_next_s = S_SHIFT;
                    end
                end else begin
                    state_next_s = state_r;
                end
            end
            S_HOLD: begin
                if (crc_ack) begin
                    state_next_s     = S_IDLE;
                    crc_next_s       = INIT;
                    cnt_next_s       = 16'd0;
                    crc_valid_next_s = 1'b0;
                    crc_out_next_s   = {WIDTH{1'b0}};
                    frame_len_next_s = 16'd0;
                end else begin
                    state_next_s = S_HOLD;
                end
            end
            default: begin
                state_next_s     = S_IDLE;
                crc_next_s       = INIT;
                cnt_next_s       = 16'd0;
                crc_valid_next_s = 1'b0;
                crc_out_next_s   = {WIDTH{1'b0}};
                frame_len_next_s = 16'd0;
            end
        endcase
    end

    // State and result registers; rst wins over any beat or ack in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            crc_r       <= INIT;
            cnt_r       <= 16'd0;
            crc_out_r   <= {WIDTH{1'b0}};
            frame_len_r <= 16'd0;
            crc_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_next_s;
            crc_r       <= crc_next_s;
            cnt_r       <= cnt_next_s;
            crc_out_r   <= crc_out_next_s;
            frame_len_r <= frame_len_next_s;
            crc_valid_r <= crc_valid_next_s;
            in_ready_r  <= (state_next_s != S_HOLD);
        end
    end

endmodule

// File: doc/serial_crc_unit.md
SERIAL_CRC_UNIT -- requirements
Module: serial_crc_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8: CRC register width in bits, legal range 4..32.
REQ-002 SHALL have parameter POLY, default 8'h07: generator polynomial with the implicit top bit omitted, WIDTH bits wide.
REQ-003 SHALL have parameter INIT, default 8'h00: CRC preset value, WIDTH bits wide.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; all state updates on posedge clk.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset, sampled on posedge clk only.
REQ-006 SHALL have port in_valid  input  1  in_bit/in_last are valid this cycle.
REQ-007 SHALL have port in_ready  output  1  block accepts a bit this cycle.
REQ-008 SHALL have port in_bit  input  1  serial data bit, MSB-first order.
REQ-009 SHALL have port in_last  input  1  marks the final bit of a frame.
REQ-010 SHALL have port crc_out  output  WIDTH  CRC of the completed frame.
REQ-011 SHALL have port frame_len  output  16  number of bits accepted in the completed frame.
REQ-012 SHALL have port crc_valid  output  1  crc_out and frame_len hold a finished result.
REQ-013 SHALL have port crc_ack  input  1  consumer takes the result.

Function
REQ-014 SHALL define a beat as a cycle with in_valid=1 and in_ready=1; no other cycle changes the CRC register.
REQ-015 SHALL implement three states: IDLE (no frame open), SHIFT (frame open), HOLD (result presented).
REQ-016 SHALL drive in_ready=1 in IDLE and SHIFT, and in_ready=0 in HOLD.
REQ-017 SHALL update on each beat: fb = crc[WIDTH-1] XOR in_bit; crc <= {crc[WIDTH-2:0],0} XOR (fb ? POLY : 0).
REQ-018 SHALL hold crc=INIT in IDLE, so the first beat of each frame operates on INIT.
REQ-019 SHALL increment the bit counter on every beat, saturating at 16'hFFFF without wrapping.
REQ-020 SHALL transition IDLE->SHIFT on a beat with in_last=0.
REQ-021 SHALL transition IDLE->HOLD or SHIFT->HOLD on a beat with in_last=1; a 1-bit frame is legal.
REQ-022 SHALL stay in SHIFT while in_valid=0, with no timeout.
REQ-023 SHALL assert crc_valid the cycle after the last beat (latency 1), with crc_out and frame_len reflecting all frame bits including the last.
REQ-024 SHALL hold crc_out, frame_len and crc_valid stable in HOLD until crc_ack=1.
REQ-025 SHALL, on crc_ack=1 in HOLD, go to IDLE next cycle: crc_valid=0, crc=INIT, counter=0.
REQ-026 SHALL accept no beat in the ack cycle, since in_ready=0 in HOLD; the next frame starts no earlier than the following cycle.
REQ-027 SHALL ignore crc_ack outside HOLD.
REQ-028 SHALL drive crc_out and frame_len to 0 whenever crc_valid=0.

Reset
REQ-029 SHALL, with rst=1 at a clock edge, force state=IDLE, crc=INIT, counter=0, crc_valid=0, crc_out=0, frame_len=0, with in_ready=1 after the edge.
REQ-030 SHALL discard a partial frame or unacknowledged result on reset mid-operation, with no crc_valid pulse.
REQ-031 SHALL give rst priority over any simultaneous beat or crc_ack.

Verification
REQ-032 SHALL pass: byte 0x01 as 8 beats MSB-first, in_last on bit 8 -> crc_valid next cycle, crc_out=0x07, frame_len=8.
REQ-033 SHALL pass: byte 0x80 -> crc_out=0x89; ASCII "123456789" (72 beats) -> crc_out=0xF4, frame_len=72.
REQ-034 SHALL pass: in_valid toggled pseudo-randomly within "123456789" -> same 0xF4; crc_ack held low 20 cycles -> outputs stable and in_ready=0 throughout.
REQ-035 SHALL pass: single beat in_bit=1 with in_last=1 from IDLE -> crc_out=0x07, frame_len=1; ack, then a second frame 0x01 -> 0x07, with no state carried over.
REQ-036 SHALL pass: rst asserted after 5 beats of a frame -> crc_valid never asserts; a following frame 0x80 -> 0x89.
REQ-037 SHALL pass: in_valid held high with in_last during the HOLD/ack cycle -> no beat accepted (frame_len unchanged) and the next frame starts the cycle after the ack.
